// File: rtl/counter_seg_display_if.sv
// counter_seg_display_if
//   Bundles the data and display signals of counter_seg_display.
//   count_in : 4-bit binary count from the upstream down counter
//   seg      : segments {g,f,e,d,c,b,a}, active-low
//   an       : digit enables, active-low (an[0] = ones, an[1] = tens)
//   tc       : single-cycle terminal-count pulse
//   master   : the side that supplies count_in and watches the display
//   slave    : the display block itself
interface counter_seg_display_if;
  logic [3:0] count_in;
  logic [6:0] seg;
  logic [1:0] an;
  logic       tc;

  modport master (output count_in, input seg, an, tc);
  modport slave  (input count_in, output seg, an, tc);
endinterface

// File: rtl/counter_seg_display.sv
// counter_seg_display
//   Shows a 4-bit count (0..15) as two decimal digits on a time-multiplexed,
//   common-anode, 2-digit seven-segment display. It also pulses tc for one
//   cycle when the count goes from nonzero to zero.
//
//   Ports:
//     clk      : single clock, rising edge
//     clear    : synchronous active-high reset
//     bus      : counter_seg_display_if.slave (count_in in; seg/an/tc out,
//                all outputs registered)
//   Parameter:
//     REFRESH_DIV : clock cycles per digit slot, >= 2
//   Build option:
//     SEG_BLANK_LEAD_EN : when defined, a leading tens digit of 0 is blanked
//
//   Scan FSM states:
//     state     | meaning
//     SLOT_ONES | ones digit is being driven (an = 2'b10 one clock later)
//     SLOT_TENS | tens digit is being driven (an = 2'b01 one clock later)
module counter_seg_display #(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                   clk,
  input  logic                   clear,
  counter_seg_display_if.slave   bus
);

  localparam int PW = $clog2(REFRESH_DIV);

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  typedef enum logic {SLOT_ONES = 1'b0, SLOT_TENS = 1'b1} slot_e;

  slot_e         sel_q, sel_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [3:0]    disp_val_q, disp_val_d;
  logic [3:0]    prev_q;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          tc_q, tc_d;
  logic          tick;
  logic          tens_dig;
  logic [3:0]    ones_dig;

  function automatic logic [6:0] encode(input logic [3:0] val);
    logic [6:0] s;
    case (val)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  assign tick = (presc_q == PW'(REFRESH_DIV - 1));

  // Prescaler and display latch. The latch is loaded only at the end of the
  // tens slot, so both digits of a scan always come from the same sample.
  always_comb begin
    presc_d    = tick ? '0 : presc_q + PW'(1);
    disp_val_d = disp_val_q;
    if (tick && (sel_q == SLOT_TENS)) begin
      disp_val_d = bus.count_in;
    end
  end

  // Scan FSM: state register
  always_ff @(posedge clk) begin
    if (clear) begin
      sel_q <= SLOT_ONES;
    end else begin
      sel_q <= sel_d;
    end
  end

  // Scan FSM: next state
  always_comb begin
    sel_d = sel_q;
    if (tick) begin
      sel_d = (sel_q == SLOT_ONES) ? SLOT_TENS : SLOT_ONES;
    end
  end

  // Scan FSM: outputs (registered below, so they lag the state by a clock)
  assign tens_dig = (disp_val_q >= 4'd10);
  assign ones_dig = tens_dig ? (disp_val_q - 4'd10) : disp_val_q;

  always_comb begin
    an_d  = 2'b10;
    seg_d = encode(ones_dig);
    if (sel_q == SLOT_TENS) begin
      an_d = 2'b01;
`ifdef SEG_BLANK_LEAD_EN
      seg_d = tens_dig ? encode(4'd1) : SEG_BLANK;
`else
      seg_d = encode({3'b000, tens_dig});
`endif
    end
  end

  // tc fires on the first sample of zero after a nonzero sample.
  assign tc_d = (bus.count_in == 4'd0) && (prev_q != 4'd0);

  always_ff @(posedge clk) begin
    if (clear) begin
      presc_q    <= '0;
      disp_val_q <= '0;
      prev_q     <= '0;
      seg_q      <= SEG_ZERO;
      an_q       <= 2'b10;
      tc_q       <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      disp_val_q <= disp_val_d;
      prev_q     <= bus.count_in;
      seg_q      <= seg_d;
      an_q       <= an_d;
      tc_q       <= tc_d;
    end
  end

  assign bus.seg = seg_q;
  assign bus.an  = an_q;
  assign bus.tc  = tc_q;

endmodule

// File: tb/tb_counter_seg_display.sv
// tb_counter_seg_display
//   Bench for counter_seg_display with REFRESH_DIV = 4. A cycle model pushes
//   the expected {seg, an, tc} for every clock into a queue; the value is
//   popped and compared just after the edge. Directed spot checks at
//   hand-derived points in the scan run alongside it. Both honour
//   SEG_BLANK_LEAD_EN.
module tb_counter_seg_display;

  localparam int RD = 4;

  logic clk;
  logic clear;
  int   vectors;
  int   miscompares;
  int   rel;

  counter_seg_display_if dut_if ();

  counter_seg_display #(.REFRESH_DIV(RD)) dut (
    .clk   (clk),
    .clear (clear),
    .bus   (dut_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h, want %h (t=%0t)", tag, got, want, $time);
    end
  endtask

  // ---------------- reference model / scoreboard ----------------
  logic [6:0] lut [10];
  initial begin
    lut[0] = 7'b1000000; lut[1] = 7'b1111001; lut[2] = 7'b0100100;
    lut[3] = 7'b0110000; lut[4] = 7'b0011001; lut[5] = 7'b0010010;
    lut[6] = 7'b0000010; lut[7] = 7'b1111000; lut[8] = 7'b0000000;
    lut[9] = 7'b0010000;
  end

  function automatic logic [6:0] tens_seg(input int t);
`ifdef SEG_BLANK_LEAD_EN
    if (t == 0) return 7'b1111111;
`endif
    return lut[t];
  endfunction

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] an;
    logic       tc;
  } exp_t;

  exp_t sb_q[$];
  int   m_presc, m_disp, m_prev;
  bit   m_sel;

  always @(posedge clk) begin
    exp_t e;
    int   cin;
    cin = int'(dut_if.count_in);
    if (clear) begin
      m_presc = 0; m_sel = 0; m_disp = 0; m_prev = 0;
      e.seg = 7'b1000000; e.an = 2'b10; e.tc = 1'b0;
    end else begin
      e.seg = m_sel ? tens_seg(m_disp / 10) : lut[m_disp % 10];
      e.an  = m_sel ? 2'b01 : 2'b10;
      e.tc  = (cin == 0) && (m_prev != 0);
      if (m_presc == RD - 1) begin
        m_presc = 0;
        if (m_sel) m_disp = cin;
        m_sel = !m_sel;
      end else begin
        m_presc++;
      end
      m_prev = cin;
    end
    sb_q.push_back(e);
  end

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("sb_seg", {9'd0, dut_if.seg}, {9'd0, e.seg});
      chk("sb_an",  {14'd0, dut_if.an}, {14'd0, e.an});
      chk("sb_tc",  {15'd0, dut_if.tc}, {15'd0, e.tc});
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(negedge clk);
    rel++;
  endtask

  task automatic go_to(input int n);
    while (rel < n) step();
  endtask

  task automatic disp_chk(input string tag, input logic [1:0] an_w, input logic [6:0] seg_w);
    chk({tag, "_an"},  {14'd0, dut_if.an}, {14'd0, an_w});
    chk({tag, "_seg"}, {9'd0, dut_if.seg}, {9'd0, seg_w});
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rel = 0;
    clear = 1'b1;
    dut_if.count_in = 4'd13;

    // Reset
    repeat (3) step();
    disp_chk("rst", 2'b10, 7'b1000000);
    chk("rst_tc", {15'd0, dut_if.tc}, 16'd0);
    clear = 1'b0;
    rel = 0;

    // Ones slot holds for 4 cycles after release, then tens slot
    for (int i = 1; i <= 4; i++) begin
      go_to(i);
      disp_chk("hold", 2'b10, 7'b1000000);
    end
    go_to(5);
    disp_chk("first_tens", 2'b01, tens_seg(0));

    // Two-digit value 13 (latched at edge 8)
    go_to(9);
    disp_chk("v13_ones", 2'b10, 7'b0110000);
    go_to(13);
    disp_chk("v13_tens", 2'b01, 7'b1111001);

    // Leading blank with 7 (latched at edge 16)
    dut_if.count_in = 4'd7;
    go_to(17);
    disp_chk("v7_ones", 2'b10, 7'b1111000);
    go_to(21);
    disp_chk("v7_tens", 2'b01, tens_seg(0));

    // Mid-scan change 9 -> 12 during tens slot
    dut_if.count_in = 4'd9;
    go_to(25);
    disp_chk("v9_ones", 2'b10, 7'b0010000);
    go_to(29);
    dut_if.count_in = 4'd12;
    go_to(31);
    disp_chk("v9_tens_hold", 2'b01, tens_seg(0));
    go_to(33);
    disp_chk("v12_ones", 2'b10, 7'b0100100);
    go_to(37);
    disp_chk("v12_tens", 2'b01, 7'b1111001);

    // Terminal count 1 -> 0, held 10 cycles
    dut_if.count_in = 4'd1;
    go_to(40);
    chk("tc_pre", {15'd0, dut_if.tc}, 16'd0);
    dut_if.count_in = 4'd0;
    go_to(41);
    chk("tc_pulse", {15'd0, dut_if.tc}, 16'd1);
    for (int i = 42; i <= 50; i++) begin
      go_to(i);
      chk("tc_hold0", {15'd0, dut_if.tc}, 16'd0);
    end

    // Reset straight into count_in = 0 (prev must be cleared)
    dut_if.count_in = 4'd5;
    clear = 1'b1;
    repeat (2) step();
    clear = 1'b0;
    dut_if.count_in = 4'd0;
    rel = 0;
    for (int i = 1; i <= 5; i++) begin
      go_to(i);
      chk("tc_rst0", {15'd0, dut_if.tc}, 16'd0);
    end

    // Mid-operation reset during tens slot while showing 13
    dut_if.count_in = 4'd13;
    go_to(21);
    disp_chk("pre_mid_tens", 2'b01, 7'b1111001);
    clear = 1'b1;
    step();
    disp_chk("mid_rst", 2'b10, 7'b1000000);
    clear = 1'b0;
    rel = 0;
    go_to(4);
    disp_chk("mid_hold", 2'b10, 7'b1000000);
    go_to(5);
    disp_chk("mid_tens", 2'b01, tens_seg(0));
    go_to(9);
    disp_chk("mid_relatch", 2'b10, 7'b0110000);

    repeat (3) step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
